// File: rtl/pp_heap_gen.sv
// Partial-product bit-heap generator for an 8x8 unsigned multiplier.
// Forms the 64 AND-array bits at enqueue time and presents them column-packed from a 2-entry queue.
module pp_heap_gen #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:0]       col0,
  output logic [1:0]       col1,
  output logic [2:0]       col2,
  output logic [3:0]       col3,
  output logic [4:0]       col4,
  output logic [5:0]       col5,
  output logic [6:0]       col6,
  output logic [7:0]       col7,
  output logic [6:0]       col8,
  output logic [5:0]       col9,
  output logic [4:0]       col10,
  output logic [3:0]       col11,
  output logic [2:0]       col12,
  output logic [1:0]       col13,
  output logic [0:0]       col14,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] txn_count
);

  typedef struct packed {
    logic [63:0]      heap;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccFull  = 2'd2
  } occ_e;

  function automatic int unsigned col_h(int unsigned k);
    return (k <= 7) ? k + 1 : 15 - k;
  endfunction

  // Bit offset of column k inside the packed 64-bit heap.
  function automatic int unsigned col_off(int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned c = 0; c < 15; c++) begin
      if (c < k) off += col_h(c);
    end
    return off;
  endfunction

  occ_e       occ_q, occ_d;
  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0] heap_new;
  entry_t     entry_new;
  entry_t     head_out;
  logic       push, pop;

  for (genvar k = 0; k < 15; k++) begin : g_col
    for (genvar j = 0; j < col_h(k); j++) begin : g_bit
      localparam logic [2:0] IA  = 3'(((k > 7) ? k - 7 : 0) + j);
      localparam logic [2:0] IB  = 3'(k - (((k > 7) ? k - 7 : 0) + j));
      localparam logic [5:0] POS = 6'(col_off(k) + j);
      assign heap_new[POS] = in_a[IA] & in_b[IB];
    end
  end

  assign entry_new = '{heap: heap_new, tag: in_tag};

  assign in_ready  = (occ_q != OccFull);
  assign out_valid = (occ_q != OccEmpty);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = push ? cnt_q + CNT_W'(1) : cnt_q;
    case (occ_q)
      OccEmpty: begin
        if (push) begin
          head_d = entry_new;
          occ_d  = OccOne;
        end
      end
      OccOne: begin
        if (push && pop) begin
          head_d = entry_new;
        end else if (push) begin
          skid_d = entry_new;
          occ_d  = OccFull;
        end else if (pop) begin
          occ_d = OccEmpty;
        end
      end
      OccFull: begin
        if (pop) begin
          head_d = skid_q;
          occ_d  = OccOne;
        end
      end
      default: occ_d = OccEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= OccEmpty;
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

  // Outputs read zero whenever nothing is presented.
  assign head_out  = out_valid ? head_q : '0;
  assign out_tag   = head_out.tag;
  assign txn_count = cnt_q;

  assign col0  = head_out.heap[0  +: 1];
  assign col1  = head_out.heap[1  +: 2];
  assign col2  = head_out.heap[3  +: 3];
  assign col3  = head_out.heap[6  +: 4];
  assign col4  = head_out.heap[10 +: 5];
  assign col5  = head_out.heap[15 +: 6];
  assign col6  = head_out.heap[21 +: 7];
  assign col7  = head_out.heap[28 +: 8];
  assign col8  = head_out.heap[36 +: 7];
  assign col9  = head_out.heap[43 +: 6];
  assign col10 = head_out.heap[49 +: 5];
  assign col11 = head_out.heap[54 +: 4];
  assign col12 = head_out.heap[58 +: 3];
  assign col13 = head_out.heap[61 +: 2];
  assign col14 = head_out.heap[63 +: 1];

endmodule

// File: tb/tb_pp_heap_gen.sv
// Self-checking bench for pp_heap_gen: directed patterns, backpressure, streaming, random, reset.
module tb_pp_heap_gen;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
  logic [CNT_W-1:0] txn_count;
  logic [0:0] col0;  logic [1:0] col1;  logic [2:0] col2;  logic [3:0] col3;
  logic [4:0] col4;  logic [5:0] col5;  logic [6:0] col6;  logic [7:0] col7;
  logic [6:0] col8;  logic [5:0] col9;  logic [4:0] col10; logic [3:0] col11;
  logic [2:0] col12; logic [1:0] col13; logic [0:0] col14;
  logic [7:0] cols [15];

  always #5 clk = ~clk;

  pp_heap_gen #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .col0(col0), .col1(col1), .col2(col2), .col3(col3), .col4(col4), .col5(col5),
    .col6(col6), .col7(col7), .col8(col8), .col9(col9), .col10(col10), .col11(col11),
    .col12(col12), .col13(col13), .col14(col14), .out_tag(out_tag), .txn_count(txn_count)
  );

  assign cols[0]  = {7'b0, col0};  assign cols[1]  = {6'b0, col1};
  assign cols[2]  = {5'b0, col2};  assign cols[3]  = {4'b0, col3};
  assign cols[4]  = {3'b0, col4};  assign cols[5]  = {2'b0, col5};
  assign cols[6]  = {1'b0, col6};  assign cols[7]  = col7;
  assign cols[8]  = {1'b0, col8};  assign cols[9]  = {2'b0, col9};
  assign cols[10] = {3'b0, col10}; assign cols[11] = {4'b0, col11};
  assign cols[12] = {5'b0, col12}; assign cols[13] = {6'b0, col13};
  assign cols[14] = {7'b0, col14};

  typedef struct {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } txn_t;

  txn_t sb[$];
  int checks = 0;
  int errors = 0;
  int model_txn = 0;
  int pushes = 0;
  int pops = 0;
  bit stall_prev = 0;
  logic [7:0] stall_cols [15];
  logic [TAG_W-1:0] stall_tag;

  function automatic int col_h(int k);
    return (k <= 7) ? k + 1 : 15 - k;
  endfunction

  function automatic int heap_ones();
    int n = 0;
    for (int k = 0; k < 15; k++)
      for (int j = 0; j < 8; j++) n += int'(cols[k][j]);
    return n;
  endfunction

  // One clock: observe at negedge (scoreboard pop/push, stall stability), then return 1ns after posedge.
  task automatic step();
    txn_t e;
    bit bad;
    int sum, i;
    @(negedge clk);
    if (stall_prev && out_valid) begin
      bad = (out_tag !== stall_tag);
      for (int k = 0; k < 15; k++) if (cols[k] !== stall_cols[k]) bad = 1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL head_stable: tag %0d changed during stall, required %0d", out_tag, stall_tag);
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_tag  = out_tag;
    for (int k = 0; k < 15; k++) stall_cols[k] = cols[k];
    if (out_valid && out_ready) begin
      pops++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: tag %0d presented, required no entry", out_tag);
      end else begin
        e = sb.pop_front();
        bad = 0;
        sum = 0;
        for (int k = 0; k < 15; k++) begin
          for (int j = 0; j < col_h(k); j++) begin
            i = ((k > 7) ? k - 7 : 0) + j;
            if (cols[k][j] !== (e.a[i] & e.b[k-i])) bad = 1;
            sum += int'(cols[k][j]) << k;
          end
        end
        if (bad) begin
          errors++;
          $display("FAIL heap_bits: a=%h b=%h col7=%h col14=%b, required AND-array bits", e.a, e.b,
                   cols[7], cols[14][0]);
        end
        checks++;
        if (sum !== int'(e.a) * int'(e.b)) begin
          errors++;
          $display("FAIL heap_sum: weighted sum %0d, required %0d", sum, int'(e.a) * int'(e.b));
        end
        checks++;
        if (out_tag !== e.tag) begin
          errors++;
          $display("FAIL out_tag: got %0d, required %0d", out_tag, e.tag);
        end
      end
    end
    if (in_valid && in_ready) begin
      e.a = in_a; e.b = in_b; e.tag = in_tag;
      sb.push_back(e);
      pushes++;
      model_txn++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || txn_count !== '0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b ready=%b cnt=%0d, required 0/1/0", out_valid, in_ready,
               txn_count);
    end
    checks++;
    if (heap_ones() !== 0 || out_tag !== '0) begin
      errors++;
      $display("FAIL reset_outputs: %0d heap ones tag=%0d, required 0/0", heap_ones(), out_tag);
    end
    rst = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || txn_count !== '0) begin
      errors++;
      $display("FAIL reset_release: valid=%b ready=%b cnt=%0d, required 0/1/0", out_valid, in_ready,
               txn_count);
    end
  endtask

  task automatic test_all_ones();
    bit bad;
    out_ready = 1'b1;
    drive(8'hFF, 8'hFF, 4'd3);
    step();
    in_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 15; k++) if (cols[k] !== 8'((1 << col_h(k)) - 1)) bad = 1;
    checks++;
    if (out_valid !== 1'b1 || bad || out_tag !== 4'd3 || txn_count !== 16'd1) begin
      errors++;
      $display("FAIL all_ones: valid=%b ones=%0d tag=%0d cnt=%0d, required 1/64/3/1", out_valid,
               heap_ones(), out_tag, txn_count);
    end
    step();
  endtask

  task automatic test_single_bits();
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    int         pk [3];
    logic [7:0] pc [3];
    pa = '{8'h01, 8'h80, 8'h80};
    pb = '{8'h80, 8'h01, 8'h80};
    pk = '{7, 7, 14};
    pc = '{8'h01, 8'h80, 8'h01};
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive(pa[n], pb[n], 4'(n + 8));
      step();
      in_valid = 1'b0;
      checks++;
      if (cols[pk[n]] !== pc[n] || heap_ones() !== 1) begin
        errors++;
        $display("FAIL single_bit%0d: col%0d=%h with %0d ones, required %h with 1", n, pk[n],
                 cols[pk[n]], heap_ones(), pc[n]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(8'h12, 8'h34, 4'd5);
    step();
    checks++;
    if (in_ready !== 1'b1 || out_tag !== 4'd5) begin
      errors++;
      $display("FAIL bp_first: ready=%b tag=%0d, required 1/5", in_ready, out_tag);
    end
    drive(8'h56, 8'h78, 4'd6);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_tag !== 4'd5) begin
      errors++;
      $display("FAIL bp_full: ready=%b tag=%0d, required 0/5", in_ready, out_tag);
    end
    drive(8'h9A, 8'hBC, 4'd7);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_tag !== 4'd5 || txn_count !== CNT_W'(model_txn)) begin
      errors++;
      $display("FAIL bp_held: ready=%b tag=%0d cnt=%0d, required 0/5/%0d", in_ready, out_tag,
               txn_count, model_txn);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_tag !== 4'd6) begin
      errors++;
      $display("FAIL bp_first_pop: ready=%b tag=%0d, required 1/6", in_ready, out_tag);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_tag !== 4'd7) begin
      errors++;
      $display("FAIL bp_order: tag=%0d, required 7", out_tag);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      drive(8'($urandom), 8'($urandom), 4'($urandom));
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream%0d: valid=%b ready=%b, required 1/1", n, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: valid=%b pending=%0d, required 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_random();
    int p0, q0, t0, cyc;
    p0 = pushes; q0 = pops; t0 = model_txn; cyc = 0;
    while (pushes - p0 < 1000 && cyc < 20000) begin
      in_valid = 1'($urandom);
      in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'($urandom);
      out_ready = 1'($urandom);
      step();
      cyc++;
      checks++;
      if (txn_count !== CNT_W'(model_txn)) begin
        errors++;
        $display("FAIL rand_count: got %0d, required %0d", txn_count, CNT_W'(model_txn));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10 && out_valid; n++) step();
    checks++;
    if (pushes - p0 != 1000 || pops - q0 != 1000 || out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL rand_totals: pushed %0d popped %0d valid=%b, required 1000/1000/0",
               pushes - p0, pops - q0, out_valid);
    end
    checks++;
    if (txn_count !== CNT_W'(t0 + 1000)) begin
      errors++;
      $display("FAIL rand_txn: got %0d, required %0d", txn_count, CNT_W'(t0 + 1000));
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(8'h11, 8'h22, 4'd1);
    step();
    drive(8'h33, 8'h44, 4'd2);
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_full: ready=%b valid=%b, required 0/1", in_ready, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || txn_count !== '0 || heap_ones() !== 0) begin
      errors++;
      $display("FAIL ar_immediate: valid=%b ready=%b cnt=%0d ones=%0d, required 0/1/0/0",
               out_valid, in_ready, txn_count, heap_ones());
    end
    sb.delete();
    model_txn = 0;
    stall_prev = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(8'hA5, 8'h5A, 4'd9);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd9 || txn_count !== 16'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_post_push: valid=%b tag=%0d cnt=%0d ready=%b, required 1/9/1/1",
               out_valid, out_tag, txn_count, in_ready);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_alone: valid=%b, required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_bits();
    test_back_to_back();
    test_streaming();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
